// File: rtl/cam_i2c_cfg_sequencer.sv
// Power-up camera register loader: walks a {reg_addr16, reg_data16} table and writes each
// pair to the sensor as one I2C burst through the i2c_opencores Avalon-MM slave.
module cam_i2c_cfg_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h36,
    parameter logic [15:0] PRESCALE    = 16'd99,
    parameter int          NUM_ENTRIES = 64,
    parameter int          TBL_AW      = 8,
    parameter int          MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic [2:0]        avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [7:0]        avm_writedata,
    input  logic [7:0]        avm_readdata,
    input  logic              avm_waitrequest
);
    localparam int                RW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TBL_AW-1:0] LAST = TBL_AW'(NUM_ENTRIES - 1);
    localparam logic [RW-1:0]     RMAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT0, S_INIT1, S_INIT2, S_FETCH_W, S_FETCH_L, S_TXR, S_CR,
        S_POLL, S_POLL_GAP, S_STOP_CR, S_STOP_POLL, S_STOP_GAP, S_NEXT, S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              error_q, error_d;
    logic [2:0]        avm_address_q, avm_address_d;
    logic [7:0]        avm_wdata_q, avm_wdata_d;
    logic              avm_write_q, avm_write_d;
    logic              avm_read_q, avm_read_d;

    logic xfer_done;
    logic sr_tip;
    logic sr_nack;
    logic unused_sr;

    assign xfer_done = (avm_write_q | avm_read_q) & ~avm_waitrequest;
    assign sr_tip    = avm_readdata[1];
    assign sr_nack   = avm_readdata[7];
    // Only TIP and RxACK of the status register steer the sequence.
    assign unused_sr = ^{avm_readdata[6:2], avm_readdata[0]};

    function automatic logic [7:0] tx_byte(input logic [2:0] k, input logic [31:0] sh);
        case (k)
            3'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
            3'd1:    tx_byte = sh[31:24];
            3'd2:    tx_byte = sh[23:16];
            3'd3:    tx_byte = sh[15:8];
            default: tx_byte = sh[7:0];
        endcase
    endfunction

    function automatic logic [7:0] cr_byte(input logic [2:0] k);
        if (k == 3'd0)      cr_byte = 8'h90;
        else if (k == 3'd4) cr_byte = 8'h50;
        else                cr_byte = 8'h10;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            retry_q       <= '0;
            tbl_addr_q    <= '0;
            error_q       <= 1'b0;
            avm_address_q <= '0;
            avm_wdata_q   <= '0;
            avm_write_q   <= 1'b0;
            avm_read_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            retry_q       <= retry_d;
            tbl_addr_q    <= tbl_addr_d;
            error_q       <= error_d;
            avm_address_q <= avm_address_d;
            avm_wdata_q   <= avm_wdata_d;
            avm_write_q   <= avm_write_d;
            avm_read_q    <= avm_read_d;
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        retry_d    = retry_q;
        tbl_addr_d = tbl_addr_q;
        shadow_d   = shadow_q;
        error_d    = error_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_INIT0;
                error_d = 1'b0;
                retry_d = '0;
                k_d     = '0;
            end
            S_INIT0: if (xfer_done) state_d = S_INIT1;
            S_INIT1: if (xfer_done) state_d = S_INIT2;
            S_INIT2: if (xfer_done) begin
                tbl_addr_d = '0;
                state_d    = S_FETCH_W;
            end
            // Table ROM is registered: data for a new address arrives one cycle later.
            S_FETCH_W: state_d = S_FETCH_L;
            S_FETCH_L: begin
                shadow_d = tbl_data;
                k_d      = '0;
                state_d  = S_TXR;
            end
            S_TXR: if (xfer_done) state_d = S_CR;
            S_CR:  if (xfer_done) state_d = S_POLL;
            S_POLL: if (xfer_done) begin
                if (sr_tip)           state_d = S_POLL_GAP;
                else if (sr_nack)     state_d = S_STOP_CR;
                else if (k_q == 3'd4) state_d = S_NEXT;
                else begin
                    k_d     = k_q + 3'd1;
                    state_d = S_TXR;
                end
            end
            S_POLL_GAP: state_d = S_POLL;
            S_STOP_CR:  if (xfer_done) state_d = S_STOP_POLL;
            S_STOP_POLL: if (xfer_done) begin
                if (sr_tip) state_d = S_STOP_GAP;
                else if (retry_q < RMAX) begin
                    retry_d = retry_q + 1'b1;
                    k_d     = '0;
                    state_d = S_TXR;
                end else begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_STOP_GAP: state_d = S_STOP_POLL;
            S_NEXT: begin
                retry_d = '0;
                if (tbl_addr_q == LAST) state_d = S_FIN;
                else begin
                    tbl_addr_d = tbl_addr_q + 1'b1;
                    state_d    = S_FETCH_W;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus request for the state being entered is registered so strobes hold through stalls.
    always_comb begin
        busy          = (state_q != S_IDLE) && (state_q != S_FIN);
        done          = (state_q == S_FIN);
        avm_address_d = avm_address_q;
        avm_wdata_d   = avm_wdata_q;
        avm_write_d   = 1'b0;
        avm_read_d    = 1'b0;
        case (state_d)
            S_INIT0: begin
                avm_write_d = 1'b1; avm_address_d = 3'd0; avm_wdata_d = PRESCALE[7:0];
            end
            S_INIT1: begin
                avm_write_d = 1'b1; avm_address_d = 3'd1; avm_wdata_d = PRESCALE[15:8];
            end
            S_INIT2: begin
                avm_write_d = 1'b1; avm_address_d = 3'd2; avm_wdata_d = 8'h80;
            end
            S_TXR: begin
                avm_write_d = 1'b1; avm_address_d = 3'd3; avm_wdata_d = tx_byte(k_d, shadow_d);
            end
            S_CR: begin
                avm_write_d = 1'b1; avm_address_d = 3'd4; avm_wdata_d = cr_byte(k_d);
            end
            S_STOP_CR: begin
                avm_write_d = 1'b1; avm_address_d = 3'd4; avm_wdata_d = 8'h40;
            end
            S_POLL, S_STOP_POLL: begin
                avm_read_d = 1'b1; avm_address_d = 3'd4;
            end
            default: ;
        endcase
    end

    assign error         = error_q;
    assign tbl_addr      = tbl_addr_q;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_wdata_q;
    assign avm_write     = avm_write_q;
    assign avm_read      = avm_read_q;

endmodule

// File: tb/tb_cam_i2c_cfg_sequencer.sv
// Bench for cam_i2c_cfg_sequencer: randomized I2C-core slave and table, write stream
// compared against an expected list built from the programming rules.
module tb_cam_i2c_cfg_sequencer;
    localparam int          NE = 3;
    localparam int          MR = 2;
    localparam logic [15:0] PS = 16'h1234;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [7:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic [2:0]  avm_address;
    logic        avm_write, avm_read;
    logic [7:0]  avm_writedata, avm_readdata;
    logic        avm_waitrequest;

    always #5 clk = ~clk;

    cam_i2c_cfg_sequencer #(
        .SLAVE_ADDR(7'h36), .PRESCALE(PS), .NUM_ENTRIES(NE), .TBL_AW(8), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .avm_address(avm_address),
        .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    // Scenario configuration (written only by the main sequence)
    logic [31:0] rom [256];
    int unsigned nack_cnt [NE];
    int unsigned nack_byte [NE];
    int unsigned stall_min = 0, stall_max = 0, tip_max = 0;

    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // i2c_opencores slave model
    int unsigned stall_len = 0, wcnt = 0, tip_left = 0;
    int unsigned s_entry = 0, s_byte = 0;
    int unsigned nk_left [NE];
    logic        sr_nack = 1'b0;

    assign avm_waitrequest = (avm_write | avm_read) && (wcnt < stall_len);
    assign avm_readdata    = {sr_nack, 5'b0, (tip_left != 0), 1'b0};

    always @(posedge clk) begin
        if (!(avm_write | avm_read)) wcnt <= 0;
        else if (avm_waitrequest) wcnt <= wcnt + 1;
        else begin : xfer
            int unsigned b;
            logic nk;
            wcnt      <= 0;
            stall_len <= $urandom_range(stall_max, stall_min);
            if (avm_read) begin
                if (tip_left != 0) tip_left <= tip_left - 1;
            end else if (avm_address == 3'd0) begin
                s_entry <= 0;
                sr_nack <= 1'b0;
                for (int i = 0; i < NE; i++) nk_left[i] <= nack_cnt[i];
            end else if (avm_address == 3'd4) begin
                tip_left <= $urandom_range(tip_max, 0);
                if (avm_writedata == 8'h40) sr_nack <= 1'b0;
                else begin
                    b  = (avm_writedata == 8'h90) ? 0 : s_byte + 1;
                    nk = (s_entry < NE) && (b == nack_byte[s_entry]) && (nk_left[s_entry] != 0);
                    s_byte  <= b;
                    sr_nack <= nk;
                    if (nk) nk_left[s_entry] <= nk_left[s_entry] - 1;
                    else if (avm_writedata == 8'h50) s_entry <= s_entry + 1;
                end
            end
        end
    end

    // Bus monitor
    logic [10:0] got_q [$];
    int unsigned done_cnt = 0, ovl_err = 0, stab_err = 0;
    logic        hold_v = 1'b0;
    logic [12:0] hold_s = '0;

    always @(negedge clk) begin
        if (avm_write && !avm_waitrequest) got_q.push_back({avm_address, avm_writedata});
        if (done) done_cnt <= done_cnt + 1;
        if (avm_write && avm_read) ovl_err <= ovl_err + 1;
        if (!reset_n) hold_v <= 1'b0;
        else begin
            if (hold_v && ({avm_write, avm_read, avm_address, avm_writedata} != hold_s))
                stab_err <= stab_err + 1;
            hold_v <= (avm_write | avm_read) && avm_waitrequest;
            hold_s <= {avm_write, avm_read, avm_address, avm_writedata};
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: expected write stream, abort flag and final table index
    logic [10:0] exp_q [$];
    logic        exp_err;
    int          exp_last;

    task automatic build_exp();
        logic [7:0] by [5];
        int fails;
        bit ok;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_last = NE - 1;
        exp_q.push_back({3'd0, PS[7:0]});
        exp_q.push_back({3'd1, PS[15:8]});
        exp_q.push_back({3'd2, 8'h80});
        for (int e = 0; e < NE && !exp_err; e++) begin
            by[0] = 8'h6C;
            by[1] = rom[e][31:24];
            by[2] = rom[e][23:16];
            by[3] = rom[e][15:8];
            by[4] = rom[e][7:0];
            fails = 0;
            ok    = 1'b0;
            while (!ok && !exp_err) begin
                ok = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    exp_q.push_back({3'd3, by[k]});
                    exp_q.push_back({3'd4, (k == 0) ? 8'h90 : (k == 4) ? 8'h50 : 8'h10});
                    if (k == int'(nack_byte[e]) && fails < int'(nack_cnt[e])) begin
                        exp_q.push_back({3'd4, 8'h40});
                        fails++;
                        ok = 1'b0;
                        if (fails > MR) begin
                            exp_err  = 1'b1;
                            exp_last = e;
                        end
                        break;
                    end
                end
            end
        end
    endtask

    task automatic run_seq(input string name, input bit restart);
        int base, nd, nexp;
        bit seen;
        build_exp();
        base = got_q.size();
        nd   = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({name, ":busy_rise"}, busy, 1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 20000 && !seen; cyc++) begin
            @(negedge clk);
            start = restart && (cyc == 20);
            if (done) begin
                seen = 1'b1;
                chk({name, ":err_at_done"}, error, exp_err);
                chk({name, ":busy_at_done"}, busy, 0);
            end
        end
        start = 1'b0;
        chk({name, ":done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        chk({name, ":done_cnt"}, done_cnt - nd, 1);
        chk({name, ":error"}, error, exp_err);
        chk({name, ":tbl_addr"}, tbl_addr, exp_last);
        chk({name, ":busy_end"}, busy, 0);
        nexp = exp_q.size();
        chk({name, ":nwr"}, got_q.size() - base, nexp);
        for (int i = 0; i < nexp && base + i < got_q.size(); i++)
            chk($sformatf("%s:wr%0d", name, i), got_q[base + i], exp_q[i]);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        for (int i = 0; i < NE; i++) begin nack_cnt[i] = 0; nack_byte[i] = 0; end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:error", error, 0);
        chk("rst:write", avm_write, 0);
        chk("rst:read", avm_read, 0);
        chk("rst:tbl_addr", tbl_addr, 0);
        chk("rst:address", avm_address, 0);
        chk("rst:wdata", avm_writedata, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        rom[0] = 32'h0100_0001;
        rom[1] = 32'h3500_0020;
        rom[2] = $urandom;
        run_seq("basic", 1'b0);

        stall_min = 5; stall_max = 5;
        run_seq("stall5", 1'b0);

        stall_min = 0; stall_max = 0;
        nack_cnt[0] = 2; nack_byte[0] = 2;
        run_seq("nack2", 1'b0);
        nack_cnt[0] = 3;
        run_seq("nack3", 1'b0);
        nack_cnt[0] = 0;
        run_seq("restart_ign", 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < NE; e++) begin
                rom[e]       = $urandom;
                nack_cnt[e]  = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
                nack_byte[e] = $urandom_range(4, 0);
            end
            stall_max = $urandom_range(3, 0);
            tip_max   = $urandom_range(3, 0);
            run_seq($sformatf("rnd%0d", r), r[0]);
        end

        // Reset asserted while a CR write is stalled
        stall_min = 5; stall_max = 5; tip_max = 0;
        for (int e = 0; e < NE; e++) nack_cnt[e] = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
            @(negedge clk);
            if (avm_write && avm_address == 3'd4 && avm_waitrequest) found = 1'b1;
        end
        chk("midrst:cr_stall_seen", found, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst:write", avm_write, 0);
        chk("midrst:read", avm_read, 0);
        chk("midrst:busy", busy, 0);
        chk("midrst:done", done, 0);
        chk("midrst:address", avm_address, 0);
        chk("midrst:wdata", avm_writedata, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_seq("after_rst", 1'b0);

        chk("stable_in_stall", stab_err, 0);
        chk("no_rd_wr_overlap", ovl_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_i2c_cfg_sequencer.md
# cam_i2c_cfg_sequencer

Hardware sequencer that programs the D8M camera sensor at power-up without Nios involvement. It walks a table of 16-bit register address / 16-bit data pairs and issues each pair as one I2C write burst through an `i2c_opencores` core, using that core's 8-bit Avalon-MM slave. The block sits between the camera-side `i2c_opencores` instance and a configuration ROM. It reports busy, done and error so that MIPI reset release and the `terasic_camera` capture start can be gated on completion.

## Interface
- `SLAVE_ADDR`, 7'h36: 7-bit I2C address of the sensor.
- `PRESCALE`, 16'd99: value written to PRERhi:PRERlo (gives 100 kHz SCL at 50 MHz).
- `NUM_ENTRIES`, 64: number of table entries, 1..2^TBL_AW.
- `TBL_AW`, 8: table address width.
- `MAX_RETRY`, 2: retries per entry after NACK before the block aborts.

- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a full sequence when idle.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at sequence end, on success or abort.
- `error`  out  1  sticky abort flag; cleared by the next accepted `start`.
- `tbl_addr`  out  TBL_AW  table index.
- `tbl_data`  in  32  {reg_addr[15:0], reg_data[15:0]}; valid 1 cycle after `tbl_addr` changes.
- `avm_address`  out  3  i2c_opencores register: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR/RXR, 4 CR/SR.
- `avm_write`  out  1  Avalon write strobe.
- `avm_read`  out  1  Avalon read strobe.
- `avm_writedata`  out  8  write data.
- `avm_readdata`  in  8  read data; valid in the cycle `avm_waitrequest` is low.
- `avm_waitrequest`  in  1  slave stall.

## Operation
- Reset values:
  - `busy`, `done`, `error`, `avm_write` and `avm_read` are 0.
  - `tbl_addr`, `avm_address` and `avm_writedata` are 0.
  - The FSM is in IDLE, and the retry and byte counters are 0.
- Reset asserted mid-transfer drops the strobes immediately. The I2C bus is not cleaned up; the core is re-initialised on the next `start`.
- `start` while `busy` is ignored.
- IDLE + `start`:
  - Clear `error`.
  - Write PRERlo = PRESCALE[7:0], then PRERhi = PRESCALE[15:8], then CTR = 8'h80 (core enable).
  - Set `tbl_addr` = 0 and go to FETCH.
- FETCH: wait 1 cycle, then latch `tbl_data` into a 32-bit shadow register. Set byte counter = 0 and go to BYTE.
- BYTE: send byte k of {SLAVE_ADDR,1'b0}, addr[15:8], addr[7:0], data[15:8], data[7:0] (k = 0..4).
  - Write TXR = byte k.
  - Then write CR: 8'h90 (STA|WR) for k = 0, 8'h10 (WR) for k = 1..3, 8'h50 (WR|STO) for k = 4.
- POLL: read SR repeatedly until bit1 (TIP) = 0; issue no back-to-back reads closer than 1 idle cycle.
  - SR bit7 (RxACK) = 0: ACK. If k < 4, increment k and return to BYTE; if k = 4, go to NEXT.
  - SR bit7 = 1: NACK. Go to STOP.
- STOP: write CR = 8'h40 (STO), then poll SR until TIP = 0.
  - If retry < MAX_RETRY: increment retry, set k = 0, re-send the same entry.
  - Otherwise set `error` = 1 and go to FIN.
- NEXT: clear retry. If `tbl_addr` = NUM_ENTRIES-1, go to FIN; else increment `tbl_addr` and go to FETCH.
- FIN: pulse `done` for 1 cycle, drop `busy` in the same cycle, return to IDLE.
- `tbl_addr` keeps its last value after FIN.

## Timing
- Avalon handshake:
  - `avm_address`, `avm_writedata` and the strobe are registered and stay stable while `avm_waitrequest` = 1.
  - A transfer completes in the first cycle with the strobe high and `avm_waitrequest` = 0.
  - The strobe deasserts on the next edge unless another transfer follows.
  - `avm_write` and `avm_read` are never high together.
- With zero-wait slave and zero-poll TIP:
  - Init: 3 writes, 3 cycles.
  - Per byte: TXR write + CR write + 1 SR read = 3 cycles min; TIP is normally high for about 9 SCL periods.
- `busy` rises the cycle after `start` is sampled.
- `error` updates in the same cycle as the abort decision and is stable before `done`.
- NUM_ENTRIES = 1 works: FETCH occurs exactly once.

## Test plan
- Zero-wait slave model, TIP clear on first read, always ACK, NUM_ENTRIES = 2, table {32'h0100_0001, 32'h3500_0020}:
  - Writes after init: 3:6C 4:90 3:01 4:10 3:00 4:10 3:00 4:10 3:01 4:50, then the same pattern for 35/00/00/20.
  - Then one `done` pulse; `error` = 0.
- Init check: PRESCALE = 16'h1234 → first writes 0:34, 1:12, 2:80.
- Slave holds `avm_waitrequest` for 5 cycles on every access:
  - Address, data and strobe stay stable through the stall.
  - The write sequence is identical to the first test.
- NACK on entry 0 byte 2, MAX_RETRY = 2:
  - NACK twice: 4:40 issued, entry re-sent from 3:6C, sequence completes with `error` = 0.
  - NACK three times: abort with `error` = 1, `done` pulse, `tbl_addr` = 0.
- `start` pulsed again while `busy` → ignored, no extra init writes.
- Assert `reset_n` low during a CR write stall → strobes and outputs 0 immediately. A new `start` re-runs init from PRERlo.
